// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one double_multiplier between NREQ
// requesters. The winner's operands are latched at grant and handed to the
// multiplier over its a/b/z strobe-ack handshake. The product returns to the
// winner with a one-cycle done pulse.
module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        result,
    output logic                 busy,
    output logic [CNTW-1:0]      op_count,
    output logic [DW-1:0]        mult_a,
    output logic [DW-1:0]        mult_b,
    output logic                 a_stb,
    output logic                 b_stb,
    output logic                 c_ack,
    input  logic                 a_ack,
    input  logic                 b_ack,
    input  logic [DW-1:0]        z,
    input  logic                 c_stb
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_Z, ACK} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [DW-1:0]     result_q, result_d;
    logic              busy_q, busy_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]     mult_a_q, mult_a_d;
    logic [DW-1:0]     mult_b_q, mult_b_d;
    logic              a_stb_q, a_stb_d;
    logic              b_stb_q, b_stb_d;
    logic              c_ack_q, c_ack_d;

    logic [PW-1:0]     pick;
    logic              anyReq;

    // Round-robin search: first set request starting at ptr and wrapping
    always_comb begin
        int idx;
        pick   = ptr_q;
        anyReq = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!anyReq && req[idx]) begin
                anyReq = 1'b1;
                pick   = PW'(idx);
            end
        end
    end

    // Next-state and registered-output logic for the sharing FSM
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        result_d = result_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        a_stb_d  = a_stb_q;
        b_stb_d  = b_stb_q;
        c_ack_d  = c_ack_q;
        unique case (state_q)
            IDLE: begin
                if (anyReq) begin
                    win_d    = pick;
                    mult_a_d = req_a[int'(pick)*DW +: DW];
                    mult_b_d = req_b[int'(pick)*DW +: DW];
                    gnt_d    = NREQ'(1) << pick;
                    a_stb_d  = 1'b1;
                    b_stb_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                a_stb_d = a_stb_q && !a_ack;
                b_stb_d = b_stb_q && !b_ack;
                if (!a_stb_d && !b_stb_d) begin
                    state_d = WAIT_Z;
                end
            end
            WAIT_Z: begin
                if (c_stb) begin
                    result_d = z;
                    c_ack_d  = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (!c_stb) begin
                    c_ack_d = 1'b0;
                    done_d  = NREQ'(1) << win_q;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = cnt_q + CNTW'(1);
                    ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously so a reset drops any in-flight product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mult_a_q <= '0;
            mult_b_q <= '0;
            a_stb_q  <= 1'b0;
            b_stb_q  <= 1'b0;
            c_ack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mult_a_q <= mult_a_d;
            mult_b_q <= mult_b_d;
            a_stb_q  <= a_stb_d;
            b_stb_q  <= b_stb_d;
            c_ack_q  <= c_ack_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign result   = result_q;
    assign busy     = busy_q;
    assign op_count = cnt_q;
    assign mult_a   = mult_a_q;
    assign mult_b   = mult_b_q;
    assign a_stb    = a_stb_q;
    assign b_stb    = b_stb_q;
    assign c_ack    = c_ack_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter: a multiplier stub with programmable
// handshake delays, a queue-based round-robin reference model, and a monitor
// that scores every done pulse against the queued expectation.
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int CNTW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   reqA, reqB;
    logic [NREQ-1:0]      gnt, done;
    logic [DW-1:0]        result, multA, multB, z;
    logic                 busy, aStb, bStb, cAck, aAck, bAck, cStb;
    logic [CNTW-1:0]      opCount;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NREQ(NREQ), .DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(reqA), .req_b(reqB),
        .gnt(gnt), .done(done), .result(result), .busy(busy), .op_count(opCount),
        .mult_a(multA), .mult_b(multB), .a_stb(aStb), .b_stb(bStb), .c_ack(cAck),
        .a_ack(aAck), .b_ack(bAck), .z(z), .c_stb(cStb)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int              w;
        logic [DW-1:0]   prod;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t            sbq[$];
    logic [DW-1:0]   opA[NREQ];
    logic [DW-1:0]   opB[NREQ];
    int              remaining[NREQ];
    int              mPtr = 0;
    logic [CNTW-1:0] mCount = '0;
    int              dA = 0, dB = 0, dZ = 0;

    function automatic logic [DW-1:0] fmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    function automatic logic [DW-1:0] dbl(input int v);
        return $realtobits(real'(v));
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Multiplier stub: acks each strobe after its own delay, then presents z until acknowledged
    int              aCnt, bCnt, zCnt;
    logic            gotA, gotB;
    logic [DW-1:0]   sA, sB;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aAck <= 1'b0; bAck <= 1'b0; cStb <= 1'b0; z <= '0;
            gotA <= 1'b0; gotB <= 1'b0; aCnt <= 0; bCnt <= 0; zCnt <= 0;
            sA <= '0; sB <= '0;
        end else begin
            if (aStb && !gotA) begin
                if (aAck) begin aAck <= 1'b0; gotA <= 1'b1; sA <= multA; end
                else if (aCnt >= dA) aAck <= 1'b1;
                else aCnt <= aCnt + 1;
            end
            if (bStb && !gotB) begin
                if (bAck) begin bAck <= 1'b0; gotB <= 1'b1; sB <= multB; end
                else if (bCnt >= dB) bAck <= 1'b1;
                else bCnt <= bCnt + 1;
            end
            if (gotA && gotB && !cStb) begin
                if (zCnt >= dZ) begin cStb <= 1'b1; z <= fmul(sA, sB); end
                else zCnt <= zCnt + 1;
            end
            if (cStb && cAck) begin
                cStb <= 1'b0; gotA <= 1'b0; gotB <= 1'b0;
                aCnt <= 0; bCnt <= 0; zCnt <= 0;
            end
        end
    end

    // Monitor: scores done pulses against the queue and watches handshake invariants
    logic expectGnt = 1'b0;
    int   cAckLen = 0;
    logic prevA = 1'b0, prevB = 1'b0, prevAAck = 1'b0, prevBAck = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            expectGnt = 1'b0; cAckLen = 0;
            prevA = 1'b0; prevB = 1'b0; prevAAck = 1'b0; prevBAck = 1'b0;
        end else begin
            if (expectGnt) begin
                expectGnt = 1'b0;
                if (sbq.size() > 0) checkOutput("next grant after done", gnt, onehot(sbq[0].w));
            end
            checkOutput("gnt onehot0", $onehot0(gnt), 1);
            checkOutput("done onehot0", $onehot0(done), 1);
            checkOutput("c_ack vs strobes", cAck && (aStb || bStb), 0);
            if (prevA && !aStb) checkOutput("a_stb drop after a_ack", prevAAck, 1);
            if (prevB && !bStb) checkOutput("b_stb drop after b_ack", prevBAck, 1);
            if (cAck) cAckLen++;
            if (done != '0) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected done", done, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput("done vector", done, onehot(e.w));
                    checkOutput("result", result, e.prod);
                    checkOutput("op_count", opCount, e.cnt);
                    checkOutput("gnt low at done", gnt, 0);
                    checkOutput("busy low at done", busy, 0);
                    checkOutput("c_ack length", cAckLen, 2);
                    expectGnt = (sbq.size() > 0);
                end
                cAckLen = 0;
            end
            prevA = aStb; prevB = bStb; prevAAck = aAck; prevBAck = bAck;
        end
    end

    task automatic packOperands();
        for (int i = 0; i < NREQ; i++) begin
            reqA[i*DW +: DW] = opA[i];
            reqB[i*DW +: DW] = opB[i];
        end
    endtask

    task automatic randomOperands();
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = dbl(int'($urandom_range(0, 3000)) - 1500);
            opB[i] = dbl(int'($urandom_range(0, 3000)) - 1500);
        end
    endtask

    // One phase: requester i asks for c_i operations; the model predicts the order up front
    task automatic applyStimulus(input int c0, input int c1, input int c2, input int c3,
                                 input bit drop, input int da, input int db, input int dz);
        int  cnt[NREQ];
        int  w, firstW, guard;
        bit  pending;
        dA = da; dB = db; dZ = dz;
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
        for (int i = 0; i < NREQ; i++) remaining[i] = cnt[i];
        packOperands();
        firstW = -1;
        forever begin
            exp_t e;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (mPtr + k) % NREQ;
                if (w < 0 && cnt[idx] > 0) w = idx;
            end
            if (w < 0) break;
            if (firstW < 0) firstW = w;
            mCount = mCount + CNTW'(1);
            e.w = w; e.prod = fmul(opA[w], opB[w]); e.cnt = mCount;
            sbq.push_back(e);
            cnt[w]--;
            mPtr = (w + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) req[i] = (remaining[i] > 0);
        @(negedge clk);
        if (firstW >= 0) checkOutput("first grant latency", gnt, onehot(firstW));
        guard = 0;
        pending = 1'b1;
        while (pending && guard < 3000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (done[i] && remaining[i] > 0) begin
                    remaining[i]--;
                    if (remaining[i] == 0) req[i] = 1'b0;
                end
                if (drop && gnt[i] && req[i]) begin
                    req[i] = 1'b0;
                    reqA[i*DW +: DW] = {$urandom, $urandom};
                    reqB[i*DW +: DW] = {$urandom, $urandom};
                end
            end
            pending = 1'b0;
            for (int i = 0; i < NREQ; i++) if (remaining[i] > 0) pending = 1'b1;
            guard++;
            if (pending) @(negedge clk);
        end
        if (pending) begin
            checks++; errors++;
            $display("[TB] FAIL phase timeout: got pending requests expected all done");
            req = '0;
        end
        repeat (3) @(negedge clk);
        checkOutput("idle after phase", {busy, gnt}, 0);
        checkOutput("scoreboard drained", sbq.size(), 0);
    endtask

    // Reset while the product is outstanding: outputs clear at once and nothing completes
    task automatic resetMidOp();
        int guard;
        opA[1] = dbl(7); opB[1] = dbl(9);
        packOperands();
        dA = 0; dB = 0; dZ = 20;
        req = 4'b0010;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(gnt != '0 && !aStb && !bStb) && guard < 100);
        checkOutput("reached WAIT_Z before reset", guard < 100, 1);
        @(negedge clk);
        req = '0;
        #2 rst_n = 1'b0;
        #1 checkOutput("reset mid-op outputs",
            {gnt, done, result, busy, opCount, multA, multB, aStb, bStb, cAck}, 0);
        sbq.delete();
        mPtr = 0;
        mCount = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int dly[3];
        dly[0] = 0; dly[1] = 1; dly[2] = 5;
        req = '0; reqA = '0; reqB = '0;
        for (int i = 0; i < NREQ; i++) begin opA[i] = '0; opB[i] = '0; end
        repeat (3) @(negedge clk);
        checkOutput("reset state",
            {gnt, done, result, busy, opCount, multA, multB, aStb, bStb, cAck}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single request 2.0 x 3.0");
        opA[0] = dbl(2); opB[0] = dbl(3);
        applyStimulus(1, 0, 0, 0, 1'b0, 0, 0, 0);
        checkOutput("6.0 encoding", result, 64'h4018000000000000);

        $display("[TB] four simultaneous requests, then req2 and req0");
        randomOperands();
        applyStimulus(1, 1, 1, 1, 1'b0, 1, 0, 2);
        randomOperands();
        applyStimulus(1, 0, 1, 0, 1'b0, 0, 1, 1);

        $display("[TB] back-to-back from requester 0");
        randomOperands();
        applyStimulus(2, 0, 0, 0, 1'b0, 0, 0, 1);

        $display("[TB] requesters drop req after grant");
        randomOperands();
        applyStimulus(0, 1, 1, 0, 1'b1, 1, 1, 0);

        $display("[TB] handshake delay sweep");
        for (int a = 0; a < 3; a++) begin
            for (int b = 0; b < 3; b++) begin
                randomOperands();
                applyStimulus(1, 0, 0, 1, 1'b0, dly[a], dly[b], dly[(a + b) % 3]);
            end
        end

        $display("[TB] reset in WAIT_Z");
        resetMidOp();
        randomOperands();
        applyStimulus(0, 0, 1, 0, 1'b0, 0, 0, 0);

        $display("[TB] random phases");
        for (int p = 0; p < 25; p++) begin
            bit drop;
            int c[NREQ];
            drop = 1'($urandom_range(0, 1));
            for (int i = 0; i < NREQ; i++) c[i] = int'($urandom_range(0, drop ? 1 : 2));
            if (c[0] + c[1] + c[2] + c[3] == 0) c[$urandom_range(0, NREQ - 1)] = 1;
            randomOperands();
            applyStimulus(c[0], c[1], c[2], c[3], drop,
                          dly[$urandom_range(0, 2)], dly[$urandom_range(0, 2)], dly[$urandom_range(0, 2)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
